ghash_digit_serial: RTL
=======================

# ghash_digit_serial

Parametrised digit-serial GHASH engine for the GCM datapath: accumulates Y_i = (Y_{i-1} xor X_i)·H over GF(2^128), consuming DIGIT_BITS multiplier bits per cycle. It trades area for latency against the fixed single-width GHASH inside the current gcm core. It sits between the gcm control FSM (AAD/ciphertext blocks, hash subkey H) and the tag stage, with valid/ready handshakes on input and output.

## Interface
- DIGIT_BITS, 8, multiplier bits processed per cycle; legal values 1, 2, 4, 8, 16, 32, 64, 128.
- BLK_BITS, 128, block/field width; fixed at 128, any other value is a elaboration error.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- h_in  in  128  hash subkey H (GCM bit order, bit 127 = x^0).
- h_load  in  1  load H and clear accumulator; honoured only in IDLE.
- in_blk  in  128  block X_i (AAD or ciphertext).
- in_last  in  1  marks final block of the message; sampled with in_blk.
- in_valid  in  1  block available.
- in_ready  out  1  engine can accept a block.
- out_ghash  out  128  final GHASH value.
- out_valid  out  1  out_ghash valid.
- out_ready  in  1  consumer accepts out_ghash.
- busy  out  1  engine not in IDLE.
- aad_bits, ct_bits  in  64 each  message lengths in bits (present only with GHASH_LEN_BLK_EN).

## Operation
- Field: GCM reflected polynomial x^128+x^7+x^2+x+1; reduction constant E1000000_..._00 applied on right shift.
- Registers: H, Y accumulator, V (shifting H copy), Z operand, digit counter (log2(128/DIGIT_BITS) bits), h_loaded flag, last flag.
- States: IDLE, MULT, LEN (macro only), OUT.
- IDLE: in_ready = h_loaded. h_load: H <= h_in, Y <= 0, h_loaded <= 1; h_load has priority over in_valid in the same cycle (block not accepted). Accept (in_valid && in_ready): Z <= Y xor in_blk, V <= H, acc <= 0, cnt <= 0, last <= in_last -> MULT.
- MULT: per cycle process DIGIT_BITS bits of Z, MSB (x^0) first: for each bit, acc ^= bit ? V : 0, then V <= V>>1 with conditional xor of R. After 128/DIGIT_BITS cycles: Y <= acc; if !last -> IDLE; if last -> LEN (macro) or OUT.
- LEN: Z <= Y xor {aad_bits, ct_bits}, rerun MULT with last cleared, then OUT.
- OUT: out_valid = 1, out_ghash = Y stable; on out_ready: Y <= 0, -> IDLE. in_ready = 0.
- h_load outside IDLE ignored; in_valid outside IDLE ignored (in_ready = 0).
- Reset (any state, mid-multiply included): state IDLE, Y/H/acc/Z/V = 0, h_loaded = 0, cnt = 0; in_ready 0, out_valid 0, out_ghash 0, busy 0. Partial results discarded.

## Timing
- N = 128/DIGIT_BITS. Accept at edge k; Y updated at edge k+N.
- Non-last block: IDLE again after edge k+N; next accept earliest at edge k+N+1 (throughput one block per N+1 cycles).
- Last block, no macro: out_valid high after edge k+N; with macro, after edge k+2N+1.
- out_valid held until out_ready; out_ready while out_valid low has no effect.
- busy high from edge after accept until return to IDLE; in_ready is registered-state decoded, no combinational path from in_valid.
- DIGIT_BITS=128: N=1, full-width combinational multiply in one cycle.

## Configuration
- GHASH_LEN_BLK_EN defined: aad_bits/ct_bits ports and LEN state exist; length block appended automatically after in_last block.
- Undefined: ports and LEN absent; caller supplies length block as final in_blk with in_last.

## Test plan
- H=66e94bd4ef8a2c3b884cfa59ca342b2e, X=0388dace60b6a392f328c2b971b2fe78 (not last) then len blk 00..0080 last (macro off) -> out_ghash f38cbb1ad69223dcc3457ae5b6b0f885; intermediate Y=5e2ec746917062882c85b0685353deb7.
- Same with macro on, aad_bits=0, ct_bits=128, single last block -> f38cbb1ad69223dcc3457ae5b6b0f885, out_valid after 2N+1 cycles.
- H=80000000000000000000000000000000 (identity), X=0388dace60b6a392f328c2b971b2fe78 last (macro off) -> out_ghash equals X; H=0 -> out_ghash 0.
- Sweep DIGIT_BITS 1,8,32,128 on vector 1 -> identical result, latency exactly N per block; in_valid held high -> accepts spaced N+1 cycles.
- Hold out_ready low 20 cycles -> out_valid/out_ghash stable, in_ready 0; then next message starts from Y=0.
- Assert reset mid-MULT -> all outputs 0, in_ready 0 until h_load; h_load with in_valid same cycle -> block not accepted.

Source files
------------

// File: rtl/ghash_digit_serial.sv
// ghash_digit_serial -- digit-serial GHASH engine over GF(2^128).
// Y_i = (Y_{i-1} xor X_i) * H, processing DIGIT_BITS multiplier bits per clock,
// so one block multiply takes N = 128/DIGIT_BITS cycles.
// Optional feature macro: GHASH_LEN_BLK_EN -- when defined, the engine appends
// the {aad_bits, ct_bits} length block itself after the in_last block.
// Bit order is the GCM one: bit 127 of every 128-bit word is the x^0 coefficient.
module ghash_digit_serial #(
  parameter int DIGIT_BITS = 8,
  parameter int BLK_BITS   = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BLK_BITS-1:0] h_in,
  input  logic                h_load,
  input  logic [BLK_BITS-1:0] in_blk,
  input  logic                in_last,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [BLK_BITS-1:0] out_ghash,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
`ifdef GHASH_LEN_BLK_EN
  ,
  input  logic [63:0]         aad_bits,
  input  logic [63:0]         ct_bits
`endif
);

  // Elaboration-time guards on the configuration.
  generate
    if (BLK_BITS != 128) begin : g_bad_blk
      $error("ghash_digit_serial: BLK_BITS must be 128");
    end
    if (!(DIGIT_BITS == 1  || DIGIT_BITS == 2  || DIGIT_BITS == 4  ||
          DIGIT_BITS == 8  || DIGIT_BITS == 16 || DIGIT_BITS == 32 ||
          DIGIT_BITS == 64 || DIGIT_BITS == 128)) begin : g_bad_digit
      $error("ghash_digit_serial: DIGIT_BITS must be a power of two from 1 to 128");
    end
  endgenerate

  localparam int N     = BLK_BITS / DIGIT_BITS;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  // Reduction constant for the reflected polynomial x^128 + x^7 + x^2 + x + 1.
  localparam logic [BLK_BITS-1:0] RED = {8'hE1, {(BLK_BITS-8){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
`ifdef GHASH_LEN_BLK_EN
    ST_LEN  = 2'd3,
`endif
    ST_OUT  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [BLK_BITS-1:0] h_reg;
  logic [BLK_BITS-1:0] y_reg;
  logic [BLK_BITS-1:0] acc_reg;
  logic [BLK_BITS-1:0] z_reg;
  logic [BLK_BITS-1:0] v_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                h_loaded_reg;
  logic                last_reg;
`ifdef GHASH_LEN_BLK_EN
  logic                len_pass_reg;
`endif

  logic [BLK_BITS-1:0] acc_step;
  logic [BLK_BITS-1:0] v_step;
  logic [BLK_BITS-1:0] z_shift;
  logic                take_blk;
  logic                mult_done;

  // h_load wins over a block offered in the same IDLE cycle.
  assign take_blk  = (state_reg == ST_IDLE) && !h_load && in_valid && h_loaded_reg;
  assign mult_done = (state_reg == ST_MULT) && (cnt_reg == CNT_LAST);

  // One digit of the shift-and-add multiply: consume Z bits MSB (x^0) first.
  always_comb begin
    acc_step = acc_reg;
    v_step   = v_reg;
    for (int j = 0; j < DIGIT_BITS; j++) begin
      if (z_reg[BLK_BITS-1-j]) begin
        acc_step = acc_step ^ v_step;
      end
      v_step = {1'b0, v_step[BLK_BITS-1:1]} ^ (v_step[0] ? RED : '0);
    end
  end

  // Move the next digit of Z to the top; a full-width digit leaves nothing over.
  generate
    if (DIGIT_BITS == BLK_BITS) begin : g_zshift_full
      assign z_shift = '0;
    end else begin : g_zshift_part
      assign z_shift = {z_reg[BLK_BITS-DIGIT_BITS-1:0], {DIGIT_BITS{1'b0}}};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (take_blk) state_next = ST_MULT;
      end
      ST_MULT: begin
        if (mult_done) begin
`ifdef GHASH_LEN_BLK_EN
          if (last_reg)          state_next = ST_LEN;
          else if (len_pass_reg) state_next = ST_OUT;
          else                   state_next = ST_IDLE;
`else
          state_next = last_reg ? ST_OUT : ST_IDLE;
`endif
        end
      end
`ifdef GHASH_LEN_BLK_EN
      ST_LEN:  state_next = ST_MULT;
`endif
      ST_OUT: begin
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    in_ready  = (state_reg == ST_IDLE) && h_loaded_reg;
    out_valid = (state_reg == ST_OUT);
    busy      = (state_reg != ST_IDLE);
    out_ghash = (state_reg == ST_OUT) ? y_reg : '0;
  end

  // Datapath: subkey, accumulator and multiplier operand registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_reg        <= '0;
      y_reg        <= '0;
      acc_reg      <= '0;
      z_reg        <= '0;
      v_reg        <= '0;
      cnt_reg      <= '0;
      h_loaded_reg <= 1'b0;
      last_reg     <= 1'b0;
`ifdef GHASH_LEN_BLK_EN
      len_pass_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (h_load) begin
            h_reg        <= h_in;
            y_reg        <= '0;
            h_loaded_reg <= 1'b1;
          end else if (take_blk) begin
            z_reg    <= y_reg ^ in_blk;
            v_reg    <= h_reg;
            acc_reg  <= '0;
            cnt_reg  <= '0;
            last_reg <= in_last;
`ifdef GHASH_LEN_BLK_EN
            len_pass_reg <= 1'b0;
`endif
          end
        end
        ST_MULT: begin
          acc_reg <= acc_step;
          v_reg   <= v_step;
          z_reg   <= z_shift;
          cnt_reg <= cnt_reg + 1'b1;
          if (mult_done) begin
            y_reg <= acc_step;
          end
        end
`ifdef GHASH_LEN_BLK_EN
        ST_LEN: begin
          z_reg        <= y_reg ^ {aad_bits, ct_bits};
          v_reg        <= h_reg;
          acc_reg      <= '0;
          cnt_reg      <= '0;
          last_reg     <= 1'b0;
          len_pass_reg <= 1'b1;
        end
`endif
        ST_OUT: begin
          if (out_ready) begin
            y_reg <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
